// File: rtl/dmi_pkg.sv
// Shared DMI definitions: operation codes, arbiter state names, bus widths, request payload.
package dmi_pkg;

    localparam int unsigned DMI_ABITS = 7;
    localparam int unsigned DMI_DBITS = 32;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } dmi_arb_state_e;

    typedef struct packed {
        logic [1:0]           op;
        logic [DMI_ABITS-1:0] addr;
        logic [DMI_DBITS-1:0] data;
    } dmi_req_t;

    // Only reads and writes occupy a host slot; NOP and RSVD are dropped silently.
    function automatic logic op_valid(input logic [1:0] op);
        return (op == READ) || (op == WRITE);
    endfunction

endpackage

// File: rtl/dmi_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first pending index after 'last', modulo NREQ.
module rr_picker #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] pending,
    input  logic [GW-1:0]   last,
    output logic [GW-1:0]   grant,
    output logic            valid
);

    function automatic logic [GW-1:0] wrap(input int unsigned v);
        return GW'(v % NREQ);
    endfunction

    // Walk from the farthest candidate back to the nearest so the nearest one wins.
    always_comb begin
        grant = '0;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            if (pending[wrap(32'(last) + k)]) begin
                grant = wrap(32'(last) + k);
            end
        end
    end

    assign valid = |pending;

endmodule

// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing the Debug Module DMI port among NREQ debug hosts.
// Define DMI_ARB_TIMEOUT_EN to add a watchdog that aborts a stalled WAIT after TIMEOUT_CYCLES.
module dmi_arbiter
    import dmi_pkg::*;
#(
    parameter int unsigned NREQ           = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NREQ-1:0]                req_start,
    input  logic [NREQ-1:0][1:0]           req_op,
    input  logic [NREQ-1:0][DMI_ABITS-1:0] req_addr,
    input  logic [NREQ-1:0][DMI_DBITS-1:0] req_wdata,
    output logic [NREQ-1:0]                req_busy,
    output logic [NREQ-1:0]                req_overrun,
    output logic [NREQ-1:0]                req_finish,
    output logic [DMI_DBITS-1:0]           req_rdata,
    output logic                           req_err,
    output logic                           dmi_start,
    output logic [1:0]                     dmi_op,
    output logic [DMI_ABITS-1:0]           dmi_address,
    output logic [DMI_DBITS-1:0]           dmi_data_o,
    input  logic                           dmi_finish,
    input  logic [DMI_DBITS-1:0]           dmi_data_i
);

    localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE  = ARB_IDLE;
    localparam logic [1:0] S_ISSUE = ARB_ISSUE;
    localparam logic [1:0] S_WAIT  = ARB_WAIT;
    localparam logic [1:0] S_DONE  = ARB_DONE;

    localparam logic [GW-1:0] LAST_RST = GW'(NREQ - 1);

    if (NREQ < 2 || NREQ > 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_cfg
        $error("dmi_arbiter: NREQ must be 2..4 and TIMEOUT_CYCLES 1..65536");
    end

    logic [1:0]                  state, state_d;
    logic [GW-1:0]               grant, grant_d;
    logic [GW-1:0]               last_grant, last_grant_d;
    logic [GW-1:0]               pick;
    logic                        pick_valid;
    logic [NREQ-1:0]             pending;
    logic [NREQ-1:0]             done_clear;
    dmi_req_t [NREQ-1:0]         slot;

    logic                        start_d;
    logic [NREQ-1:0]             finish_d;
    logic [DMI_DBITS-1:0]        rdata_d;
    logic [1:0]                  op_d;
    logic [DMI_ABITS-1:0]        addr_d;
    logic [DMI_DBITS-1:0]        wdata_d;

`ifdef DMI_ARB_TIMEOUT_EN
    logic [15:0]                 wd_cnt, wd_cnt_d;
    logic                        err_d;
`endif

    rr_picker #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_picker (
        .pending (pending),
        .last    (last_grant),
        .grant   (pick),
        .valid   (pick_valid)
    );

    assign req_busy = pending;

    always_comb begin
        done_clear = '0;
        if (state == S_DONE) begin
            done_clear[grant] = 1'b1;
        end
    end

    // Host slots: a slot vacated in DONE may be refilled by a start on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            slot        <= '0;
            req_overrun <= '0;
        end else begin
            for (int i = 0; i < int'(NREQ); i++) begin
                req_overrun[i] <= 1'b0;
                if (done_clear[i]) begin
                    pending[i] <= 1'b0;
                end
                if (req_start[i] && op_valid(req_op[i])) begin
                    if (!pending[i] || done_clear[i]) begin
                        pending[i]   <= 1'b1;
                        slot[i].op   <= req_op[i];
                        slot[i].addr <= req_addr[i];
                        slot[i].data <= req_wdata[i];
                    end else begin
                        req_overrun[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Next-state and next-output logic for the single DMI transaction in flight.
    always_comb begin
        state_d      = state;
        grant_d      = grant;
        last_grant_d = last_grant;
        start_d      = 1'b0;
        finish_d     = '0;
        rdata_d      = req_rdata;
        op_d         = dmi_op;
        addr_d       = dmi_address;
        wdata_d      = dmi_data_o;
`ifdef DMI_ARB_TIMEOUT_EN
        err_d        = req_err;
        wd_cnt_d     = wd_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick;
                    op_d    = slot[pick].op;
                    addr_d  = slot[pick].addr;
                    wdata_d = slot[pick].data;
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef DMI_ARB_TIMEOUT_EN
                wd_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (dmi_finish) begin
                    rdata_d         = dmi_data_i;
                    finish_d[grant] = 1'b1;
                    state_d         = S_DONE;
`ifdef DMI_ARB_TIMEOUT_EN
                    err_d           = 1'b0;
                end else if (wd_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d         = '0;
                    err_d           = 1'b1;
                    finish_d[grant] = 1'b1;
                    state_d         = S_DONE;
                end else begin
                    wd_cnt_d        = wd_cnt + 16'd1;
`endif
                end
            end
            S_DONE: begin
                last_grant_d = grant;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            grant       <= '0;
            last_grant  <= LAST_RST;
            dmi_start   <= 1'b0;
            req_finish  <= '0;
            req_rdata   <= '0;
            dmi_op      <= '0;
            dmi_address <= '0;
            dmi_data_o  <= '0;
        end else begin
            state       <= state_d;
            grant       <= grant_d;
            last_grant  <= last_grant_d;
            dmi_start   <= start_d;
            req_finish  <= finish_d;
            req_rdata   <= rdata_d;
            dmi_op      <= op_d;
            dmi_address <= addr_d;
            dmi_data_o  <= wdata_d;
        end
    end

`ifdef DMI_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt  <= '0;
            req_err <= 1'b0;
        end else begin
            wd_cnt  <= wd_cnt_d;
            req_err <= err_d;
        end
    end
`else
    assign req_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmi_arbiter.sv
// Randomized bench for dmi_arbiter against a transaction-level reference model, plus directed scenarios.
module tb_dmi_arbiter;

    localparam int N  = 3;
    localparam int TO = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         req_start;
    logic [N-1:0][1:0]    req_op;
    logic [N-1:0][6:0]    req_addr;
    logic [N-1:0][31:0]   req_wdata;
    logic [N-1:0]         req_busy;
    logic [N-1:0]         req_overrun;
    logic [N-1:0]         req_finish;
    logic [31:0]          req_rdata;
    logic                 req_err;
    logic                 dmi_start;
    logic [1:0]           dmi_op;
    logic [6:0]           dmi_address;
    logic [31:0]          dmi_data_o;
    logic                 dmi_finish;
    logic [31:0]          dmi_data_i;

    dmi_arbiter #(.NREQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_start   (req_start),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_busy    (req_busy),
        .req_overrun (req_overrun),
        .req_finish  (req_finish),
        .req_rdata   (req_rdata),
        .req_err     (req_err),
        .dmi_start   (dmi_start),
        .dmi_op      (dmi_op),
        .dmi_address (dmi_address),
        .dmi_data_o  (dmi_data_o),
        .dmi_finish  (dmi_finish),
        .dmi_data_i  (dmi_data_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model: host slots + one transaction in service ----------------
    bit [N-1:0]  m_pend, m_ovr, old_pend, acc;
    logic [1:0]  m_op   [N];
    logic [6:0]  m_addr [N];
    logic [31:0] m_data [N];
    int          m_cur, m_age, m_last;
    bit          m_fin, m_start, m_err, was_idle;
    logic [31:0] m_rdata, m_ddata;
    logic [1:0]  m_dop;
    logic [6:0]  m_daddr;

    function automatic int rr_pick(input bit [N-1:0] p, input int last);
        for (int k = 1; k <= N; k++) begin
            if (p[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = '0; m_ovr = '0; m_cur = -1; m_age = 0; m_last = N - 1;
            m_fin = 0; m_start = 0; m_err = 0; m_rdata = '0;
            m_dop = '0; m_daddr = '0; m_ddata = '0;
            for (int i = 0; i < N; i++) begin
                m_op[i] = '0; m_addr[i] = '0; m_data[i] = '0;
            end
        end else begin
            old_pend = m_pend;
            was_idle = (m_cur < 0);
            acc      = '0;
            m_ovr    = '0;
            m_start  = 0;
            for (int i = 0; i < N; i++) begin
                if (req_start[i] && (req_op[i] == 2'd1 || req_op[i] == 2'd2)) begin
                    if (!old_pend[i] || (m_fin && m_cur == i)) begin
                        acc[i] = 1'b1;
                        m_op[i] = req_op[i]; m_addr[i] = req_addr[i]; m_data[i] = req_wdata[i];
                    end else begin
                        m_ovr[i] = 1'b1;
                    end
                end
            end
            if (m_fin) begin
                m_pend[m_cur] = 1'b0;
                m_last = m_cur;
                m_cur  = -1;
                m_fin  = 0;
            end else if (was_idle) begin
                if (old_pend != 0) begin
                    m_cur   = rr_pick(old_pend, m_last);
                    m_age   = 0;
                    m_start = 1;
                    m_dop   = m_op[m_cur];
                    m_daddr = m_addr[m_cur];
                    m_ddata = m_data[m_cur];
                end
            end else begin
                // age 0 is the issue cycle; the DM answer only counts from the first wait cycle on
                if (m_age >= 1 && dmi_finish) begin
                    m_fin = 1; m_rdata = dmi_data_i; m_err = 0;
`ifdef DMI_ARB_TIMEOUT_EN
                end else if (m_age == TO) begin
                    m_fin = 1; m_rdata = '0; m_err = 1;
`endif
                end else begin
                    m_age++;
                end
            end
            m_pend = m_pend | acc;
        end
    end

    // ---------------- event logs used by the directed literal checks ----------------
    int          st_cyc[$];
    logic [1:0]  st_op[$];
    logic [6:0]  st_addr[$];
    logic [31:0] st_data[$];
    int          fn_cyc[$];
    int          fn_host[$];
    logic [31:0] fn_rdata[$];
    logic        fn_err[$];
    int          ov_cnt[N];

    task automatic clear_logs();
        st_cyc.delete(); st_op.delete(); st_addr.delete(); st_data.delete();
        fn_cyc.delete(); fn_host.delete(); fn_rdata.delete(); fn_err.delete();
        for (int i = 0; i < N; i++) ov_cnt[i] = 0;
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        int h;
        check("busy", 32'(req_busy), 32'(m_pend));
        check("overrun", 32'(req_overrun), 32'(m_ovr));
        check("finish", 32'(req_finish), m_fin ? (32'd1 << m_cur) : 32'd0);
        check("dmi_start", 32'(dmi_start), 32'(m_start));
        if (m_cur >= 0) begin
            check("dmi_op", 32'(dmi_op), 32'(m_dop));
            check("dmi_address", 32'(dmi_address), 32'(m_daddr));
            check("dmi_data_o", dmi_data_o, m_ddata);
        end
        if (m_fin) begin
            check("req_rdata", req_rdata, m_rdata);
            check("req_err", 32'(req_err), 32'(m_err));
        end
        if (dmi_start) begin
            st_cyc.push_back(cyc); st_op.push_back(dmi_op);
            st_addr.push_back(dmi_address); st_data.push_back(dmi_data_o);
        end
        if (req_finish != 0) begin
            h = -1;
            for (int i = 0; i < N; i++) if (req_finish[i]) h = i;
            fn_cyc.push_back(cyc); fn_host.push_back(h);
            fn_rdata.push_back(req_rdata); fn_err.push_back(req_err);
        end
        for (int i = 0; i < N; i++) if (req_overrun[i]) ov_cnt[i]++;
    end

    // ---------------- DM responder ----------------
    int          dm_cnt = 0;
    int          dm_delay = 1;
    bit          dm_hang = 0, dm_stray = 0, dm_fixed = 0;
    logic [31:0] dm_fixed_val = '0;

    initial begin
        dmi_finish = 1'b0;
        dmi_data_i = '0;
        forever begin
            @(negedge clk);
            dmi_finish = 1'b0;
            dmi_data_i = dm_fixed ? dm_fixed_val : $urandom;
            if (!rst_n) begin
                dm_cnt = 0;
            end else begin
                if (dm_cnt > 0) begin
                    dm_cnt--;
                    if (dm_cnt == 0) dmi_finish = 1'b1;
                end
                if (dmi_start && !dm_hang) dm_cnt = (dm_delay != 0) ? dm_delay : int'($urandom_range(1, 5));
            end
            if (dm_stray) begin
                dmi_finish = 1'b1;
                dm_stray   = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_cur >= 0 || m_pend != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (m_cur >= 0 || m_pend != 0) begin
            total++; bad++;
            $display("FAIL wait_idle: still busy after %0d cycles", budget);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive(input int h, input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
        req_start[h] = 1'b1; req_op[h] = op; req_addr[h] = a; req_wdata[h] = d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    int t0, n;

    initial begin
        rst_n = 1'b0; req_start = '0; req_op = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(req_busy), 32'd0);
        check("rst_dmi_start", 32'(dmi_start), 32'd0);
        check("rst_rdata", req_rdata, 32'd0);
        check("rst_finish", 32'(req_finish), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // host 0 read of 0x11, DM answers after 3 cycles
        dm_delay = 3; dm_fixed = 1; dm_fixed_val = 32'hDEADBEEF;
        clear_logs();
        t0 = cyc;
        drive(0, 2'd1, 7'h11, 32'h0);
        @(negedge clk); req_start = '0;
        wait_idle(50);
        dm_fixed = 0;
        check("t1_nstart", st_cyc.size(), 1);
        check("t1_nfinish", fn_cyc.size(), 1);
        if (st_cyc.size() >= 1) begin
            check("t1_op", 32'(st_op[0]), 32'd1);
            check("t1_addr", 32'(st_addr[0]), 32'h11);
            check("t1_start_lat", st_cyc[0] - t0, 2);
        end
        if (fn_cyc.size() >= 1) begin
            check("t1_host", fn_host[0], 0);
            check("t1_rdata", fn_rdata[0], 32'hDEADBEEF);
            check("t1_err", 32'(fn_err[0]), 32'd0);
            check("t1_fin_lat", fn_cyc[0] - t0, 6);
        end

        // hosts 0 and 1 contend from reset: host 0 first, back-to-back
        apply_reset();
        dm_delay = 1;
        clear_logs();
        drive(0, 2'd2, 7'h10, 32'h1);
        drive(1, 2'd1, 7'h04, 32'h0);
        @(negedge clk); req_start = '0;
        wait_idle(50);
        check("t2_nstart", st_cyc.size(), 2);
        if (st_cyc.size() >= 2 && fn_cyc.size() >= 2) begin
            check("t2_op0", 32'(st_op[0]), 32'd2);
            check("t2_addr0", 32'(st_addr[0]), 32'h10);
            check("t2_data0", st_data[0], 32'h1);
            check("t2_op1", 32'(st_op[1]), 32'd1);
            check("t2_addr1", 32'(st_addr[1]), 32'h04);
            check("t2_host0", fn_host[0], 0);
            check("t2_host1", fn_host[1], 1);
            check("t2_b2b", st_cyc[1] - fn_cyc[0], 2);
        end else begin
            check("t2_nfinish", fn_cyc.size(), 2);
        end

        // host 1 starts again while busy
        dm_delay = 3;
        clear_logs();
        drive(1, 2'd1, 7'h05, 32'h0);
        @(negedge clk);
        drive(1, 2'd2, 7'h06, 32'h55);
        @(negedge clk); req_start = '0;
        wait_idle(50);
        check("t3_overrun", ov_cnt[1], 1);
        check("t3_nstart", st_cyc.size(), 1);
        check("t3_nfinish", fn_cyc.size(), 1);

        // op 0 is ignored
        clear_logs();
        drive(0, 2'd0, 7'h22, 32'h0);
        @(negedge clk); req_start = '0;
        check("t4_busy", 32'(req_busy[0]), 32'd0);
        repeat (8) @(negedge clk);
        check("t4_nstart", st_cyc.size(), 0);

`ifdef DMI_ARB_TIMEOUT_EN
        // DM never answers: watchdog completes with error
        dm_hang = 1;
        clear_logs();
        drive(0, 2'd1, 7'h30, 32'h0);
        @(negedge clk); req_start = '0;
        n = 0;
        while (fn_cyc.size() == 0 && n < 40) begin @(negedge clk); n++; end
        dm_hang = 0;
        check("to_nfinish", fn_cyc.size(), 1);
        if (fn_cyc.size() >= 1 && st_cyc.size() >= 1) begin
            check("to_err", 32'(fn_err[0]), 32'd1);
            check("to_rdata", fn_rdata[0], 32'd0);
            check("to_lat", fn_cyc[0] - st_cyc[0], TO + 1);
        end
        wait_idle(10);
        clear_logs();
        dm_stray = 1;
        repeat (6) @(negedge clk);
        check("to_stray_finish", fn_cyc.size(), 0);
`endif

        // reset while waiting on the DM
        dm_hang = 1;
        clear_logs();
        drive(0, 2'd1, 7'h12, 32'h0);
        @(negedge clk); req_start = '0;
        n = 0;
        while (st_cyc.size() == 0 && n < 10) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rw_busy", 32'(req_busy), 32'd0);
        check("rw_finish", 32'(req_finish), 32'd0);
        check("rw_dmi_start", 32'(dmi_start), 32'd0);
        check("rw_dmi_addr", 32'(dmi_address), 32'd0);
        check("rw_dmi_op", 32'(dmi_op), 32'd0);
        check("rw_rdata", req_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; dm_hang = 0; dm_delay = 2;
        clear_logs();
        repeat (4) @(negedge clk);
        check("rw_stale_finish", fn_cyc.size(), 0);
        drive(2, 2'd1, 7'h72, 32'h0);
        drive(1, 2'd1, 7'h71, 32'h0);
        drive(0, 2'd1, 7'h70, 32'h0);
        @(negedge clk); req_start = '0;
        wait_idle(60);
        check("rw_nfinish", fn_cyc.size(), 3);
        if (fn_cyc.size() >= 3) begin
            check("rw_order0", fn_host[0], 0);
            check("rw_order1", fn_host[1], 1);
            check("rw_order2", fn_host[2], 2);
        end

        // randomized traffic, checked every cycle by the model
        dm_delay = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                req_start[i] = ($urandom_range(0, 3) == 0);
                req_op[i]    = 2'($urandom_range(0, 3));
                req_addr[i]  = 7'($urandom);
                req_wdata[i] = $urandom;
            end
            if ($urandom_range(0, 49) == 0) dm_stray = 1;
            @(negedge clk);
        end
        req_start = '0;
        wait_idle(200);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmi_arbiter.md
# dmi_arbiter

Shares the single DMI trivial-bus port of the Debug Module between `NREQ` debug hosts: the JTAG DTM plus secondary hosts such as a UART debug bridge. Each host issues one read or write at a time through a start/finish pulse handshake; the arbiter queues one request per host, serialises requests to the DM in round-robin order and returns read data and status to the owner. Sits in the `clk` domain between the DTM's CDC-synchronised DMI outputs and the DM.

## Interface
- `NREQ`, 2: number of requesters (2..4).
- `TIMEOUT_CYCLES`, 1024: cycles in WAIT before the watchdog aborts (only with the macro).
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_start`  in  [NREQ]  per-host one-cycle request pulse.
- `req_op`  in  [NREQ][1:0]  1=read, 2=write, 0/3 ignored.
- `req_addr`  in  [NREQ][6:0]  DM register address.
- `req_wdata`  in  [NREQ][31:0]  write data.
- `req_busy`  out  [NREQ]  host slot occupied.
- `req_overrun`  out  [NREQ]  one-cycle pulse: start dropped because slot busy.
- `req_finish`  out  [NREQ]  one-cycle completion pulse.
- `req_rdata`  out  [31:0]  read data, valid with any `req_finish`.
- `req_err`  out  1  timeout flag, valid with `req_finish`.
- `dmi_start`  out  1  one-cycle pulse to DM.
- `dmi_op`, `dmi_address`, `dmi_data_o`  out  2/7/32  held from ISSUE until DONE.
- `dmi_finish`  in  1  DM completion pulse.
- `dmi_data_i`  in  [31:0]  DM read data, valid with `dmi_finish`.

## Operation
- Per-host slot: `pending`, op, addr, wdata. A `req_start` with op 1 or 2 while `!pending` latches the payload and sets `pending`. If op is 0/3, the start is ignored with no flag. If the slot is pending, the start is dropped and `req_overrun` pulses.
- `req_busy[i] = pending[i]`.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if any pending, `rr_picker` picks the first pending index after `last_grant`, modulo NREQ. Latches `grant`, then goes to ISSUE.
  - ISSUE: `dmi_start`=1 for exactly this cycle, then WAIT.
  - WAIT: on `dmi_finish`, capture `dmi_data_i` into `req_rdata`, set `req_err`=0, go to DONE.
  - DONE: `req_finish[grant]`=1, clear `pending[grant]`, set `last_grant`=`grant`, go to IDLE.
- `dmi_finish` outside WAIT is ignored.
- Write requests still pass `dmi_data_i` through to `req_rdata`; hosts ignore it.
- A host whose slot clears in DONE may start again in the same cycle; the new request is accepted.
- Reset mid-transaction: all state is dropped, and no finish is delivered to any host.
- Reset values:
  - all outputs 0;
  - `last_grant` = NREQ-1, so host 0 wins the first contention;
  - all slots empty.

## Timing
- `req_start` sampled at edge E0 with the FSM in IDLE: ISSUE after E1 (`dmi_start` high in cycle E1..E2), WAIT after E2.
- `dmi_finish` sampled at edge F: `req_finish` high during the cycle after F.
- Minimum start-to-finish latency is 4 edges.
- Back-to-back service: next `dmi_start` is 2 cycles after the previous `req_finish`.
- Round-robin fairness: with all hosts continuously pending, each is served once per NREQ transactions.

## Configuration
- `DMI_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on WAIT entry and increments each WAIT cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 with no `dmi_finish`, go to DONE with `req_err`=1 and `req_rdata`=0.
  - `dmi_finish` coinciding with the timeout cycle wins: normal completion, `req_err`=0.
- Undefined: no counter; WAIT lasts until `dmi_finish`; `req_err` is tied 0.

## Structure
- Shared package `dmi_pkg`:
  - `dmi_op_e` (NOP=0, READ=1, WRITE=2, RSVD=3);
  - `dmi_arb_state_e`;
  - `DMI_ABITS`=7 and `DMI_DBITS`=32.
- Sub-module `rr_picker`: combinational round-robin priority encoder. Inputs `pending[NREQ]`, `last[$clog2(NREQ)]`; outputs `grant`, `valid`.

## Test plan
- Host 0 read, addr 0x11, DM returns 0xDEADBEEF after 3 cycles → one `dmi_start`, `dmi_op`=1, `dmi_address`=0x11; `req_finish[0]` once, `req_rdata`=0xDEADBEEF, `req_err`=0.
- Hosts 0 and 1 start in the same cycle (write 0x10 ← 0x1, read 0x04) → host 0 served first, then host 1; exactly two `dmi_start`s, and `dmi_data_o`=0x1 during the first.
- Host 1 starts again while busy → `req_overrun[1]` pulses; only one DM transaction occurs.
- Host 0 start with op=0 → no `req_busy`, no `dmi_start`.
- With `DMI_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=8, DM never finishes → `req_finish` 8 cycles after WAIT entry, `req_err`=1, `req_rdata`=0. A later stray `dmi_finish` in IDLE has no effect.
- `rst_n` asserted during WAIT → all outputs 0 immediately. After release, host 0 wins the first contention and no stale `req_finish` appears.
